pose_round_controller: RTL and testbench

Sequences one game round of pose matching around the skeleton scorer. Steps through NUM_POSES model poses, runs a per-pose frame countdown, and arms the scorer for exactly one frame. It then captures each 3-bit score and accumulates a round total for display.
Sits between the frame timing generator, the model-pose ROM (driven by pose_index_out) and the scorer (driven by score_enable_out).

---
 rtl/pose_round_controller.sv | 180 ++++++++++++++++++
 tb/tb_pose_round_controller.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pose_round_controller.sv
// Round sequencer for pose matching: per-pose frame countdown, one-frame scorer arm, score capture and round total.
// Optional macro SCORE_TIMEOUT_EN forces a zero score after TIMEOUT_FRAMES unanswered frame starts in SCORING.
module pose_round_controller #(
    parameter int unsigned NUM_POSES        = 8,
    parameter int unsigned COUNTDOWN_FRAMES = 90,
    parameter int unsigned TIMEOUT_FRAMES   = 4
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   start_in,
    input  logic                                   abort_in,
    input  logic                                   frame_start_in,
    input  logic                                   score_valid_in,
    input  logic [2:0]                             score_in,
    output logic                                   score_enable_out,
    output logic [((NUM_POSES > 1) ? $clog2(NUM_POSES) : 1)-1:0] pose_index_out,
    output logic [$clog2(COUNTDOWN_FRAMES+1)-1:0]  countdown_out,
    output logic [2:0]                             last_score_out,
    output logic                                   pose_score_valid_out,
    output logic [$clog2(7*NUM_POSES+1)-1:0]       total_score_out,
    output logic                                   busy_out,
    output logic                                   round_done_out,
    output logic                                   timeout_out
);

    localparam int unsigned PW = (NUM_POSES > 1) ? $clog2(NUM_POSES) : 1;
    localparam int unsigned CW = $clog2(COUNTDOWN_FRAMES + 1);
    localparam int unsigned TW = $clog2(7 * NUM_POSES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNTDOWN,
        S_ARM,
        S_SCORING,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pose_d;
    logic [CW-1:0] countdown_d;
    logic [2:0]    last_d;
    logic [TW-1:0] total_d;
    logic          enable_d;
    logic          psv_d;
    logic          busy_d;
    logic          done_d;
    logic          accept;
    logic [2:0]    accept_score;

`ifdef SCORE_TIMEOUT_EN
    localparam int unsigned OW = $clog2(TIMEOUT_FRAMES + 1);
    logic [OW-1:0] wait_q, wait_d;
    logic          timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_FRAMES == 0);
    assign timeout_out        = 1'b0;
`endif

    // Next-state and next-output logic; abort beats everything except reset
    always_comb begin
        state_d      = state_q;
        pose_d       = pose_index_out;
        countdown_d  = countdown_out;
        last_d       = last_score_out;
        total_d      = total_score_out;
        enable_d     = 1'b0;
        psv_d        = 1'b0;
        accept       = 1'b0;
        accept_score = score_in;
`ifdef SCORE_TIMEOUT_EN
        wait_d       = wait_q;
        timeout_d    = 1'b0;
`endif
        if (abort_in && (state_q == S_COUNTDOWN || state_q == S_ARM || state_q == S_SCORING)) begin
            state_d     = S_IDLE;
            countdown_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_in) begin
                        state_d     = S_COUNTDOWN;
                        pose_d      = '0;
                        total_d     = '0;
                        last_d      = '0;
                        countdown_d = CW'(COUNTDOWN_FRAMES);
                    end
                end
                S_COUNTDOWN: begin
                    if (frame_start_in) begin
                        if (countdown_out > CW'(1)) begin
                            countdown_d = countdown_out - CW'(1);
                        end else begin
                            countdown_d = '0;
                            state_d     = S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    if (frame_start_in) begin
                        enable_d = 1'b1;
                        state_d  = S_SCORING;
`ifdef SCORE_TIMEOUT_EN
                        wait_d   = '0;
`endif
                    end
                end
                S_SCORING: begin
                    if (score_valid_in) begin
                        accept = 1'b1;
`ifdef SCORE_TIMEOUT_EN
                    end else if (frame_start_in) begin
                        if (wait_q == OW'(TIMEOUT_FRAMES - 1)) begin
                            accept       = 1'b1;
                            accept_score = 3'd0;
                            timeout_d    = 1'b1;
                        end else begin
                            wait_d = wait_q + OW'(1);
                        end
`endif
                    end
                    if (accept) begin
                        last_d  = accept_score;
                        total_d = total_score_out + TW'(accept_score);
                        psv_d   = 1'b1;
                        if (pose_index_out == PW'(NUM_POSES - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            pose_d      = pose_index_out + PW'(1);
                            countdown_d = CW'(COUNTDOWN_FRAMES);
                            state_d     = S_COUNTDOWN;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_COUNTDOWN) || (state_d == S_ARM) || (state_d == S_SCORING);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q              <= S_IDLE;
            pose_index_out       <= '0;
            countdown_out        <= '0;
            last_score_out       <= '0;
            total_score_out      <= '0;
            score_enable_out     <= 1'b0;
            pose_score_valid_out <= 1'b0;
            busy_out             <= 1'b0;
            round_done_out       <= 1'b0;
        end else begin
            state_q              <= state_d;
            pose_index_out       <= pose_d;
            countdown_out        <= countdown_d;
            last_score_out       <= last_d;
            total_score_out      <= total_d;
            score_enable_out     <= enable_d;
            pose_score_valid_out <= psv_d;
            busy_out             <= busy_d;
            round_done_out       <= done_d;
        end
    end

`ifdef SCORE_TIMEOUT_EN
    // Unanswered-frame counter and timeout strobe
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wait_q      <= '0;
            timeout_out <= 1'b0;
        end else begin
            wait_q      <= wait_d;
            timeout_out <= timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_pose_round_controller.sv
// Self-checking bench for pose_round_controller: directed scenarios plus randomized traffic against a round-level model.
module tb_pose_round_controller;

    localparam int NP = 2;
    localparam int CF = 3;
    localparam int TO = 2;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       start_in = 1'b0;
    logic       abort_in = 1'b0;
    logic       frame_start_in = 1'b0;
    logic       score_valid_in = 1'b0;
    logic [2:0] score_in = 3'd0;
    logic       score_enable_out;
    logic [0:0] pose_index_out;
    logic [1:0] countdown_out;
    logic [2:0] last_score_out;
    logic       pose_score_valid_out;
    logic [3:0] total_score_out;
    logic       busy_out;
    logic       round_done_out;
    logic       timeout_out;

    int checks = 0;
    int errors = 0;

    pose_round_controller #(
        .NUM_POSES(NP), .COUNTDOWN_FRAMES(CF), .TIMEOUT_FRAMES(TO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .abort_in(abort_in),
        .frame_start_in(frame_start_in), .score_valid_in(score_valid_in), .score_in(score_in),
        .score_enable_out(score_enable_out), .pose_index_out(pose_index_out),
        .countdown_out(countdown_out), .last_score_out(last_score_out),
        .pose_score_valid_out(pose_score_valid_out), .total_score_out(total_score_out),
        .busy_out(busy_out), .round_done_out(round_done_out), .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    // Round-level model: the list of recorded scores defines pose index and total
    localparam int M_IDLE = 0, M_WAIT_FRAMES = 1, M_WAIT_ARM = 2, M_WAIT_SCORE = 3, M_DONE = 4;
    int phase;
    int scores[$];
    int m_last, m_cd, m_waited;
    bit m_en, m_psv, m_to;

    function automatic void model_reset();
        phase = M_IDLE; scores.delete(); m_last = 0; m_cd = 0; m_waited = 0;
        m_en = 0; m_psv = 0; m_to = 0;
    endfunction

    function automatic void model_record(input int s);
        scores.push_back(s);
        m_last = s;
        m_psv = 1;
        if (scores.size() == NP) phase = M_DONE;
        else begin phase = M_WAIT_FRAMES; m_cd = CF; end
    endfunction

    function automatic int model_total();
        int t = 0;
        foreach (scores[i]) t += scores[i];
        return t;
    endfunction

    function automatic int model_pose();
        return (scores.size() > NP - 1) ? NP - 1 : scores.size();
    endfunction

    function automatic void model_step(input bit s, a, f, v, input int sc);
        bit busy = (phase == M_WAIT_FRAMES || phase == M_WAIT_ARM || phase == M_WAIT_SCORE);
        m_en = 0; m_psv = 0; m_to = 0;
        if (a && busy) begin
            phase = M_IDLE; m_cd = 0;
        end else if (phase == M_WAIT_SCORE) begin
            if (v) model_record(sc);
`ifdef SCORE_TIMEOUT_EN
            else if (f) begin
                m_waited++;
                if (m_waited >= TO) begin model_record(0); m_to = 1; end
            end
`endif
        end else if (phase == M_WAIT_FRAMES) begin
            if (f) begin
                m_cd = m_cd - 1;
                if (m_cd <= 0) begin m_cd = 0; phase = M_WAIT_ARM; end
            end
        end else if (phase == M_WAIT_ARM) begin
            if (f) begin m_en = 1; phase = M_WAIT_SCORE; m_waited = 0; end
        end else if (s) begin
            scores.delete(); m_last = 0; m_cd = CF; phase = M_WAIT_FRAMES;
        end
    endfunction

    task automatic cyc(input bit s, a, f, v, input logic [2:0] sc);
        start_in = s; abort_in = a; frame_start_in = f; score_valid_in = v; score_in = sc;
        @(posedge clk_in);
        model_step(s, a, f, v, int'(sc));
        #1;
        start_in = 0; abort_in = 0; frame_start_in = 0; score_valid_in = 0; score_in = 3'd0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        model_reset();
    endtask

    // Start a round and run frames up to the cycle SCORING is entered
    task automatic reach_scoring();
        for (int i = 0; i < CF + 1; i++) cyc(0, 0, 1, 0, 3'd0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({score_enable_out, pose_index_out, countdown_out, last_score_out, pose_score_valid_out,
             total_score_out, busy_out, round_done_out, timeout_out} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got pose=%0d cd=%0d last=%0d total=%0d busy=%0d done=%0d, need all 0",
                     pose_index_out, countdown_out, last_score_out, total_score_out, busy_out, round_done_out);
        end
    endtask

    task automatic test_round_flow();
        do_reset();
        cyc(1, 0, 0, 0, 3'd0);
        checks++;
        if (countdown_out !== 2'd3 || busy_out !== 1'b1 || pose_index_out !== 1'b0) begin
            errors++;
            $display("FAIL start_load: cd=%0d busy=%0d pose=%0d, need 3 1 0", countdown_out, busy_out, pose_index_out);
        end
        for (int i = 2; i >= 0; i--) begin
            cyc(0, 0, 1, 0, 3'd0);
            checks++;
            if (countdown_out !== 2'(i)) begin
                errors++;
                $display("FAIL countdown_step: cd=%0d, need %0d", countdown_out, i);
            end
        end
        checks++;
        if (score_enable_out !== 1'b0 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL arm_idle: en=%0d busy=%0d, need 0 1", score_enable_out, busy_out);
        end
        cyc(0, 0, 1, 0, 3'd0);
        checks++;
        if (score_enable_out !== 1'b1) begin
            errors++;
            $display("FAIL enable_pulse: en=%0d, need 1", score_enable_out);
        end
        cyc(0, 0, 1, 0, 3'd0);
        checks++;
        if (score_enable_out !== 1'b0 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL enable_single: en=%0d busy=%0d, need 0 1", score_enable_out, busy_out);
        end
        cyc(0, 0, 0, 1, 3'd5);
        checks++;
        if (pose_score_valid_out !== 1'b1 || last_score_out !== 3'd5 || total_score_out !== 4'd5 ||
            pose_index_out !== 1'b1 || countdown_out !== 2'd3) begin
            errors++;
            $display("FAIL first_score: psv=%0d last=%0d total=%0d pose=%0d cd=%0d, need 1 5 5 1 3",
                     pose_score_valid_out, last_score_out, total_score_out, pose_index_out, countdown_out);
        end
        cyc(0, 0, 0, 0, 3'd0);
        checks++;
        if (pose_score_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL psv_single: psv=%0d, need 0", pose_score_valid_out);
        end
        reach_scoring();
        cyc(0, 0, 0, 1, 3'd6);
        checks++;
        if (total_score_out !== 4'd11 || round_done_out !== 1'b1 || busy_out !== 1'b0 ||
            pose_score_valid_out !== 1'b1 || last_score_out !== 3'd6 || pose_index_out !== 1'b1) begin
            errors++;
            $display("FAIL round_end: total=%0d done=%0d busy=%0d psv=%0d last=%0d pose=%0d, need 11 1 0 1 6 1",
                     total_score_out, round_done_out, busy_out, pose_score_valid_out, last_score_out, pose_index_out);
        end
        cyc(0, 1, 1, 1, 3'd7);
        checks++;
        if (round_done_out !== 1'b1 || total_score_out !== 4'd11 || pose_score_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: done=%0d total=%0d psv=%0d, need 1 11 0",
                     round_done_out, total_score_out, pose_score_valid_out);
        end
    endtask

    task automatic test_abort();
        do_reset();
        cyc(1, 0, 0, 0, 3'd0);
        reach_scoring();
        cyc(0, 0, 0, 1, 3'd5);
        cyc(0, 0, 1, 0, 3'd0);
        cyc(0, 1, 0, 0, 3'd0);
        checks++;
        if (busy_out !== 1'b0 || countdown_out !== 2'd0 || total_score_out !== 4'd5 ||
            pose_index_out !== 1'b1 || round_done_out !== 1'b0 || last_score_out !== 3'd5) begin
            errors++;
            $display("FAIL abort_hold: busy=%0d cd=%0d total=%0d pose=%0d done=%0d last=%0d, need 0 0 5 1 0 5",
                     busy_out, countdown_out, total_score_out, pose_index_out, round_done_out, last_score_out);
        end
        cyc(1, 0, 0, 0, 3'd0);
        checks++;
        if (total_score_out !== 4'd0 || pose_index_out !== 1'b0 || countdown_out !== 2'd3 || last_score_out !== 3'd0) begin
            errors++;
            $display("FAIL restart_clear: total=%0d pose=%0d cd=%0d last=%0d, need 0 0 3 0",
                     total_score_out, pose_index_out, countdown_out, last_score_out);
        end
    endtask

    task automatic test_ignored_inputs();
        do_reset();
        cyc(0, 1, 0, 0, 3'd0);
        checks++;
        if (busy_out !== 1'b0 || countdown_out !== 2'd0) begin
            errors++;
            $display("FAIL abort_idle: busy=%0d cd=%0d, need 0 0", busy_out, countdown_out);
        end
        cyc(1, 0, 0, 0, 3'd0);
        cyc(0, 0, 0, 1, 3'd7);
        checks++;
        if (pose_score_valid_out !== 1'b0 || total_score_out !== 4'd0 || last_score_out !== 3'd0) begin
            errors++;
            $display("FAIL score_in_countdown: psv=%0d total=%0d last=%0d, need 0 0 0",
                     pose_score_valid_out, total_score_out, last_score_out);
        end
        cyc(0, 0, 1, 0, 3'd0);
        cyc(1, 0, 0, 0, 3'd0);
        checks++;
        if (countdown_out !== 2'd2 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: cd=%0d busy=%0d, need 2 1", countdown_out, busy_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(1, 0, 0, 0, 3'd0);
        reach_scoring();
        cyc(0, 0, 1, 1, 3'd4);
        checks++;
        if (pose_score_valid_out !== 1'b1 || countdown_out !== 2'd3 || total_score_out !== 4'd4 ||
            score_enable_out !== 1'b0 || timeout_out !== 1'b0) begin
            errors++;
            $display("FAIL score_and_frame: psv=%0d cd=%0d total=%0d en=%0d to=%0d, need 1 3 4 0 0",
                     pose_score_valid_out, countdown_out, total_score_out, score_enable_out, timeout_out);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        cyc(1, 0, 0, 0, 3'd0);
        reach_scoring();
        cyc(0, 0, 1, 0, 3'd0);
        cyc(0, 0, 1, 0, 3'd0);
`ifdef SCORE_TIMEOUT_EN
        checks++;
        if (timeout_out !== 1'b1 || pose_score_valid_out !== 1'b1 || last_score_out !== 3'd0 ||
            pose_index_out !== 1'b1 || countdown_out !== 2'd3) begin
            errors++;
            $display("FAIL timeout_fire: to=%0d psv=%0d last=%0d pose=%0d cd=%0d, need 1 1 0 1 3",
                     timeout_out, pose_score_valid_out, last_score_out, pose_index_out, countdown_out);
        end
        reach_scoring();
        cyc(0, 0, 1, 0, 3'd0);
        cyc(0, 0, 1, 1, 3'd3);
        checks++;
        if (timeout_out !== 1'b0 || last_score_out !== 3'd3 || total_score_out !== 4'd3 || round_done_out !== 1'b1) begin
            errors++;
            $display("FAIL timeout_score_wins: to=%0d last=%0d total=%0d done=%0d, need 0 3 3 1",
                     timeout_out, last_score_out, total_score_out, round_done_out);
        end
`else
        checks++;
        if (timeout_out !== 1'b0 || pose_score_valid_out !== 1'b0 || busy_out !== 1'b1 || pose_index_out !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: to=%0d psv=%0d busy=%0d pose=%0d, need 0 0 1 0",
                     timeout_out, pose_score_valid_out, busy_out, pose_index_out);
        end
`endif
    endtask

    task automatic test_random();
        int mbusy, mdone;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom % 8) == 0, ($urandom % 50) == 0, ($urandom % 3) == 0,
                ($urandom % 4) == 0, 3'($urandom));
            mbusy = (phase == M_WAIT_FRAMES || phase == M_WAIT_ARM || phase == M_WAIT_SCORE);
            mdone = (phase == M_DONE);
            checks++;
            if (busy_out !== 1'(mbusy) || round_done_out !== 1'(mdone)) begin
                errors++;
                $display("FAIL rand_status n=%0d: busy=%0d done=%0d, need %0d %0d", n, busy_out, round_done_out, mbusy, mdone);
            end
            checks++;
            if (countdown_out !== 2'(m_cd) || pose_index_out !== 1'(model_pose())) begin
                errors++;
                $display("FAIL rand_progress n=%0d: cd=%0d pose=%0d, need %0d %0d", n, countdown_out, pose_index_out, m_cd, model_pose());
            end
            checks++;
            if (last_score_out !== 3'(m_last) || total_score_out !== 4'(model_total())) begin
                errors++;
                $display("FAIL rand_scores n=%0d: last=%0d total=%0d, need %0d %0d", n, last_score_out, total_score_out, m_last, model_total());
            end
            checks++;
            if (score_enable_out !== m_en || pose_score_valid_out !== m_psv || timeout_out !== m_to) begin
                errors++;
                $display("FAIL rand_pulses n=%0d: en=%0d psv=%0d to=%0d, need %0d %0d %0d",
                         n, score_enable_out, pose_score_valid_out, timeout_out, m_en, m_psv, m_to);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_flow();
        test_abort();
        test_ignored_inputs();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
